// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the multi-cycle RV32I core.
//   - state_e          : control FSM states
//   - OP_* / F3_*      : opcode and funct3 encodings used by decode and the LSU
//   - EBREAK_INST      : instruction word that halts the core
//   - DEFAULT_RESET_PC : default reset vector
package npc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_IWAIT = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MREQ  = 3'd3,
        ST_MWAIT = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/npc_lsu.sv
// npc_lsu: combinational load/store lane logic.
//   funct3    : access size / signedness from the instruction
//   addr_lo   : low two bits of the byte address
//   rs2_data  : store source register
//   rdata     : word-aligned load data from the data bus
//   wdata     : store data replicated into every lane
//   wstrb     : byte enables for the store
//   load_data : selected and extended load result
module npc_lsu
    import npc_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lane replication and byte-enable generation; misaligned addresses simply shift the strobe.
    always_comb begin
        wdata = rs2_data;
        wstrb = 4'b0000;
        case (funct3)
            F3_B: begin
                wdata = {4{rs2_data[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            F3_H: begin
                wdata = {2{rs2_data[15:0]}};
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            end
            F3_W: begin
                wdata = rs2_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = rs2_data;
                wstrb = 4'b0000;
            end
        endcase
    end

    // Lane selection and sign/zero extension of the returned load word.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        load_data = rdata;
        case (addr_lo)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'h000000, byte_s};
            F3_HU:   load_data = {16'h0000, half_s};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/npc_mc_core.sv
// npc_mc_core: multi-cycle RV32I core with valid/ready instruction and data buses.
// Ports: clk, rst_n (async active-low); imem_* fetch request/response bus;
//        dmem_* load/store request/response bus; pc (current PC); halt (ebreak seen).
// Optional macro NPC_COMMIT_EN adds commit_valid/commit_pc/commit_inst retire trace outputs.
// State: control FSM, instruction register ir_r, pc_r, 32x32 register file (x0 hard zero).
module npc_mc_core
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] pc,
    output logic        halt
`ifdef NPC_COMMIT_EN
    ,
    output logic        commit_valid,
    output logic [31:0] commit_pc,
    output logic [31:0] commit_inst
`endif
);

    state_e      state_r, state_next_s;
    logic [31:0] ir_r, pc_r;
    logic [31:0] rf_r [0:31];
    logic        imem_req_valid_r, dmem_req_valid_r, halt_r, dmem_we_r;
    logic [31:0] dmem_addr_r, dmem_wdata_r;
    logic [3:0]  dmem_wstrb_r;

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s;
    logic [31:0] rs1_val_s, rs2_val_s, imm_s, op_a_s, op_b_s, sra_s, alu_res_s;
    logic [31:0] pc_plus4_s, jalr_sum_s, exec_target_s, exec_wb_s;
    logic        taken_s, regw_s, is_load_s, is_store_s, is_ebreak_s;
    logic [1:0]  lsu_addr_lo_s;
    logic [31:0] lsu_wdata_s, lsu_load_s;
    logic [3:0]  lsu_wstrb_s;

    logic        ir_we_s, rf_we_s, pc_we_s, mreq_load_s, retire_s;
    logic [31:0] rf_wdata_s, pc_next_s;

    assign opcode_s    = ir_r[6:0];
    assign funct3_s    = ir_r[14:12];
    assign rd_s        = ir_r[11:7];
    assign rs1_val_s   = rf_r[ir_r[19:15]];
    assign rs2_val_s   = rf_r[ir_r[24:20]];
    assign pc_plus4_s  = pc_r + 32'd4;
    assign jalr_sum_s  = rs1_val_s + imm_s;
    assign is_load_s   = (opcode_s == OP_LOAD);
    assign is_store_s  = (opcode_s == OP_STORE);
    assign is_ebreak_s = (ir_r == EBREAK_INST);

    assign imem_req_valid = imem_req_valid_r;
    assign imem_addr      = pc_r;
    assign dmem_req_valid = dmem_req_valid_r;
    assign dmem_we        = dmem_we_r;
    assign dmem_addr      = dmem_addr_r;
    assign dmem_wdata     = dmem_wdata_r;
    assign dmem_wstrb     = dmem_wstrb_r;
    assign pc             = pc_r;
    assign halt           = halt_r;

    // Immediate generation by instruction format.
    always_comb begin
        imm_s = 32'h0000_0000;
        case (opcode_s)
            OP_IMM, OP_LOAD, OP_JALR: imm_s = {{20{ir_r[31]}}, ir_r[31:20]};
            OP_STORE:                 imm_s = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
            OP_BRANCH:                imm_s = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm_s = {ir_r[31:12], 12'h000};
            OP_JAL:                   imm_s = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
            default:                  imm_s = 32'h0000_0000;
        endcase
    end

    // ALU: register/immediate arithmetic; every other opcode uses it as an adder (addresses, lui, auipc).
    always_comb begin
        op_a_s = rs1_val_s;
        op_b_s = imm_s;
        if (opcode_s == OP_AUIPC) begin
            op_a_s = pc_r;
        end else if (opcode_s == OP_LUI) begin
            op_a_s = 32'h0000_0000;
        end else begin
            op_a_s = rs1_val_s;
        end
        if (opcode_s == OP_REG) begin
            op_b_s = rs2_val_s;
        end else begin
            op_b_s = imm_s;
        end
        // Kept as its own statement so the shift stays arithmetic.
        sra_s = $signed(op_a_s) >>> op_b_s[4:0];
        alu_res_s = op_a_s + op_b_s;
        if ((opcode_s == OP_REG) || (opcode_s == OP_IMM)) begin
            case (funct3_s)
                3'b000:  alu_res_s = ((opcode_s == OP_REG) && ir_r[30]) ? (op_a_s - op_b_s) : (op_a_s + op_b_s);
                3'b001:  alu_res_s = op_a_s << op_b_s[4:0];
                3'b010:  alu_res_s = {31'd0, ($signed(op_a_s) < $signed(op_b_s))};
                3'b011:  alu_res_s = {31'd0, (op_a_s < op_b_s)};
                3'b100:  alu_res_s = op_a_s ^ op_b_s;
                3'b101:  alu_res_s = ir_r[30] ? sra_s : (op_a_s >> op_b_s[4:0]);
                3'b110:  alu_res_s = op_a_s | op_b_s;
                3'b111:  alu_res_s = op_a_s & op_b_s;
                default: alu_res_s = op_a_s + op_b_s;
            endcase
        end else begin
            alu_res_s = op_a_s + op_b_s;
        end
    end

    // Branch condition, next-PC target, write-back value and register-write enable for EXEC.
    always_comb begin
        case (funct3_s)
            3'b000:  taken_s = (rs1_val_s == rs2_val_s);
            3'b001:  taken_s = (rs1_val_s != rs2_val_s);
            3'b100:  taken_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            3'b101:  taken_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            3'b110:  taken_s = (rs1_val_s < rs2_val_s);
            3'b111:  taken_s = (rs1_val_s >= rs2_val_s);
            default: taken_s = 1'b0;
        endcase
        exec_target_s = pc_plus4_s;
        exec_wb_s     = alu_res_s;
        regw_s        = 1'b0;
        case (opcode_s)
            OP_JAL: begin
                exec_target_s = pc_r + imm_s;
                exec_wb_s     = pc_plus4_s;
                regw_s        = 1'b1;
            end
            OP_JALR: begin
                exec_target_s = {jalr_sum_s[31:1], 1'b0};
                exec_wb_s     = pc_plus4_s;
                regw_s        = 1'b1;
            end
            OP_BRANCH: begin
                exec_target_s = taken_s ? (pc_r + imm_s) : pc_plus4_s;
            end
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG: begin
                regw_s = 1'b1;
            end
            default: begin
                regw_s = 1'b0;
            end
        endcase
    end

    // The LSU sees the fresh ALU address in EXEC and the latched bus address while a load returns.
    assign lsu_addr_lo_s = (state_r == ST_MWAIT) ? dmem_addr_r[1:0] : alu_res_s[1:0];

    npc_lsu u_lsu (
        .funct3    (funct3_s),
        .addr_lo   (lsu_addr_lo_s),
        .rs2_data  (rs2_val_s),
        .rdata     (dmem_rdata),
        .wdata     (lsu_wdata_s),
        .wstrb     (lsu_wstrb_s),
        .load_data (lsu_load_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; the fetch handshake needs the registered valid, which is low for the first cycle out of reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: state_next_s = (imem_req_valid_r && imem_req_ready) ? ST_IWAIT : ST_FETCH;
            ST_IWAIT: state_next_s = imem_rsp_valid ? ST_EXEC : ST_IWAIT;
            ST_EXEC: begin
                if (is_ebreak_s) begin
                    state_next_s = ST_HALT;
                end else if (is_load_s || is_store_s) begin
                    state_next_s = ST_MREQ;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_MREQ:  state_next_s = dmem_req_ready ? ST_MWAIT : ST_MREQ;
            ST_MWAIT: state_next_s = dmem_rsp_valid ? ST_FETCH : ST_MWAIT;
            ST_HALT:  state_next_s = ST_HALT;
            default:  state_next_s = ST_FETCH;
        endcase
    end

    // FSM output strobes: ir capture, register/PC retire and data-request launch.
    always_comb begin
        ir_we_s     = 1'b0;
        rf_we_s     = 1'b0;
        rf_wdata_s  = exec_wb_s;
        pc_we_s     = 1'b0;
        pc_next_s   = pc_plus4_s;
        mreq_load_s = 1'b0;
        retire_s    = 1'b0;
        case (state_r)
            ST_IWAIT: begin
                ir_we_s = imem_rsp_valid;
            end
            ST_EXEC: begin
                if (is_ebreak_s) begin
                    retire_s = 1'b0;
                end else if (is_load_s || is_store_s) begin
                    mreq_load_s = 1'b1;
                end else begin
                    rf_we_s   = regw_s;
                    pc_we_s   = 1'b1;
                    pc_next_s = exec_target_s;
                    retire_s  = 1'b1;
                end
            end
            ST_MWAIT: begin
                if (dmem_rsp_valid) begin
                    rf_we_s    = is_load_s;
                    rf_wdata_s = lsu_load_s;
                    pc_we_s    = 1'b1;
                    retire_s   = 1'b1;
                end else begin
                    rf_we_s = 1'b0;
                end
            end
            default: begin
                ir_we_s = 1'b0;
            end
        endcase
    end

    // Instruction register and program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r <= 32'h0000_0000;
            pc_r <= RESET_PC;
        end else begin
            if (ir_we_s) begin
                ir_r <= imem_rdata;
            end
            if (pc_we_s) begin
                pc_r <= pc_next_s;
            end
        end
    end

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'h0000_0000;
            end
        end else if (rf_we_s && (rd_s != 5'd0)) begin
            rf_r[rd_s] <= rf_wdata_s;
        end
    end

    // Registered bus requests and halt flag, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_req_valid_r <= 1'b0;
            dmem_req_valid_r <= 1'b0;
            halt_r           <= 1'b0;
            dmem_we_r        <= 1'b0;
            dmem_addr_r      <= 32'h0000_0000;
            dmem_wdata_r     <= 32'h0000_0000;
            dmem_wstrb_r     <= 4'b0000;
        end else begin
            imem_req_valid_r <= (state_next_s == ST_FETCH);
            dmem_req_valid_r <= (state_next_s == ST_MREQ);
            halt_r           <= (state_next_s == ST_HALT);
            if (mreq_load_s) begin
                dmem_we_r    <= is_store_s;
                dmem_addr_r  <= alu_res_s;
                dmem_wdata_r <= is_store_s ? lsu_wdata_s : 32'h0000_0000;
                dmem_wstrb_r <= is_store_s ? lsu_wstrb_s : 4'b0000;
            end
        end
    end

`ifdef NPC_COMMIT_EN
    logic        commit_valid_r;
    logic [31:0] commit_pc_r, commit_inst_r;

    assign commit_valid = commit_valid_r;
    assign commit_pc    = commit_pc_r;
    assign commit_inst  = commit_inst_r;

    // Retire trace: one-cycle pulse carrying the PC and word of the instruction just retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid_r <= 1'b0;
            commit_pc_r    <= 32'h0000_0000;
            commit_inst_r  <= 32'h0000_0000;
        end else begin
            commit_valid_r <= retire_s;
            if (retire_s) begin
                commit_pc_r   <= pc_r;
                commit_inst_r <= ir_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_npc_mc_core.sv
// tb_npc_mc_core: directed-program bench for npc_mc_core with simple valid/ready memory models.
module tb_npc_mc_core;

    localparam logic [31:0] RST_VEC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] pc;
    logic        halt;
`ifdef NPC_COMMIT_EN
    logic        commit_valid;
    logic [31:0] commit_pc, commit_inst;
    int          n_commit = 0;
`endif

    logic [31:0] imem [0:63];
    int          n_pass = 0;
    int          n_checks = 0;
    int          i_stall, i_lat, d_lat;
    logic [31:0] d_rdata_cfg;

    npc_mc_core #(.RESET_PC(RST_VEC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .pc             (pc),
        .halt           (halt)
`ifdef NPC_COMMIT_EN
        ,
        .commit_valid   (commit_valid),
        .commit_pc      (commit_pc),
        .commit_inst    (commit_inst)
`endif
    );

    always #5 clk = ~clk;

`ifdef NPC_COMMIT_EN
    always @(negedge clk) begin
        if (commit_valid) n_commit <= n_commit + 1;
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nops();
        for (int k = 0; k < 64; k++) imem[k] = 32'h0000_0013;
    endtask

    // Memory models: decide ready/response at the falling edge from the DUT's registered requests.
    initial begin
        logic        i_busy, d_busy;
        int          i_wait, d_wait;
        logic [31:0] off;
        logic [5:0]  i_idx;
        i_busy = 1'b0; d_busy = 1'b0; i_wait = 0; d_wait = 0; i_idx = 6'd0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'h0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                i_busy = 1'b0; d_busy = 1'b0;
                imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
                dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                if (i_busy) begin
                    if (i_wait == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rdata = imem[i_idx];
                        i_busy = 1'b0;
                    end else begin
                        i_wait--;
                    end
                end
                imem_req_ready = 1'b0;
                if (imem_req_valid && !i_busy) begin
                    if (i_stall > 0) begin
                        i_stall--;
                    end else begin
                        imem_req_ready = 1'b1;
                        i_busy = 1'b1;
                        i_wait = i_lat - 1;
                        off = imem_addr - RST_VEC;
                        i_idx = off[7:2];
                    end
                end
                dmem_rsp_valid = 1'b0;
                if (d_busy) begin
                    if (d_wait == 0) begin
                        dmem_rsp_valid = 1'b1;
                        dmem_rdata = d_rdata_cfg;
                        d_busy = 1'b0;
                    end else begin
                        d_wait--;
                    end
                end
                dmem_req_ready = 1'b0;
                if (dmem_req_valid && !d_busy) begin
                    dmem_req_ready = 1'b1;
                    d_busy = 1'b1;
                    d_wait = d_lat - 1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic got;
        logic any_req;
`ifdef NPC_COMMIT_EN
        int   c0;
`endif
        rst_n = 1'b0; i_stall = 0; i_lat = 1; d_lat = 1; d_rdata_cfg = 32'h8001_0000;
        fill_nops();
        imem[0]  = 32'h0050_0093; // addi x1,x0,5
        imem[1]  = 32'h0A50_0093; // addi x1,x0,0xA5
        imem[2]  = 32'h1000_0113; // addi x2,x0,0x100
        imem[3]  = 32'h0011_00A3; // sb   x1,1(x2)
        imem[4]  = 32'h0021_1183; // lh   x3,2(x2)
        imem[5]  = 32'h0021_5203; // lhu  x4,2(x2)
        imem[6]  = 32'h0031_2023; // sw   x3,0(x2)
        imem[7]  = 32'h0000_0463; // beq  x0,x0,+8
        imem[8]  = 32'h0010_0293; // addi x5,x0,1 (skipped)
        imem[9]  = 32'h0080_036F; // jal  x6,+8
        imem[10] = 32'h0020_0293; // addi x5,x0,2 (skipped)
        imem[11] = 32'h0041_83B3; // add  x7,x3,x4
        imem[12] = 32'h1234_5437; // lui  x8,0x12345
        imem[13] = 32'h0010_0073; // ebreak

        repeat (3) tick();
        check_eq("rst_pc", pc, RST_VEC);
        check_eq("rst_halt", {31'd0, halt}, 32'd0);
        check_eq("rst_ivalid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_dvalid", {31'd0, dmem_req_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("first_ivalid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("first_iaddr", imem_addr, RST_VEC);

        cyc = 0;
        while (!(imem_req_valid && imem_addr == 32'h8000_0004) && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("cpi_alu", cyc, 32'd3);
        check_eq("addi_x1", dut.rf_r[1], 32'd5);
        i_stall = 4;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("stall_valid", {31'd0, imem_req_valid}, 32'd1);
            check_eq("stall_addr", imem_addr, 32'h8000_0004);
            check_eq("stall_pc", pc, 32'h8000_0004);
        end

        cyc = 0;
        while (!dmem_req_valid && cyc < 100) begin tick(); cyc++; end
        check_eq("sb_seen", {31'd0, dmem_req_valid}, 32'd1);
        check_eq("sb_addr", dmem_addr, 32'h0000_0101);
        check_eq("sb_we", {31'd0, dmem_we}, 32'd1);
        check_eq("sb_wstrb", {28'd0, dmem_wstrb}, 32'h0000_0002);
        check_eq("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);

        cyc = 0;
        while (!(dmem_req_valid && !dmem_we) && cyc < 100) begin tick(); cyc++; end
        check_eq("lh_addr", dmem_addr, 32'h0000_0102);
        d_lat = 3;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (dmem_rsp_valid) got = 1'b1;
            else check_eq("lh_early_x3", dut.rf_r[3], 32'd0);
        end
        check_eq("lh_rsp_seen", {31'd0, got}, 32'd1);
        check_eq("lh_x3", dut.rf_r[3], 32'hFFFF_8001);
        d_lat = 1;

        cyc = 0;
        while (!dmem_req_valid && cyc < 100) begin tick(); cyc++; end
        check_eq("lhu_we", {31'd0, dmem_we}, 32'd0);
        check_eq("lhu_wstrb", {28'd0, dmem_wstrb}, 32'd0);
        cyc = 0;
        while (!(dmem_req_valid && dmem_we) && cyc < 100) begin tick(); cyc++; end
        check_eq("lhu_x4", dut.rf_r[4], 32'h0000_8001);
        check_eq("sw_addr", dmem_addr, 32'h0000_0100);
        check_eq("sw_wdata", dmem_wdata, 32'hFFFF_8001);
        check_eq("sw_wstrb", {28'd0, dmem_wstrb}, 32'h0000_000F);

        cyc = 0;
        while (!halt && cyc < 200) begin tick(); cyc++; end
        check_eq("a_halt", {31'd0, halt}, 32'd1);
        check_eq("a_halt_pc", pc, 32'h8000_0034);
        check_eq("beq_skip_x5", dut.rf_r[5], 32'd0);
        check_eq("jal_x6", dut.rf_r[6], 32'h8000_0028);
        check_eq("add_x7", dut.rf_r[7], 32'h0000_0002);
        check_eq("lui_x8", dut.rf_r[8], 32'h1234_5000);
        any_req = 1'b0;
        repeat (20) begin tick(); any_req = any_req | imem_req_valid | dmem_req_valid; end
        check_eq("a_no_req", {31'd0, any_req}, 32'd0);
`ifdef NPC_COMMIT_EN
        check_eq("a_commits", n_commit, 32'd11);
`endif

        // Second program: ebreak at RESET_PC+8, and a write to x0 that must vanish.
        rst_n = 1'b0;
        tick();
        check_eq("rst2_pc", pc, RST_VEC);
        check_eq("rst2_halt", {31'd0, halt}, 32'd0);
        fill_nops();
        imem[0] = 32'h0050_0093; // addi x1,x0,5
        imem[1] = 32'h0070_0013; // addi x0,x0,7
        imem[2] = 32'h0010_0073; // ebreak
`ifdef NPC_COMMIT_EN
        c0 = n_commit;
`endif
        rst_n = 1'b1;
        cyc = 0;
        while (!halt && cyc < 100) begin tick(); cyc++; end
        check_eq("b_halt", {31'd0, halt}, 32'd1);
        check_eq("b_halt_pc", pc, 32'h8000_0008);
        check_eq("b_x1", dut.rf_r[1], 32'd5);
        check_eq("b_x0", dut.rf_r[0], 32'd0);
        any_req = 1'b0;
        repeat (20) begin tick(); any_req = any_req | imem_req_valid | dmem_req_valid; end
        check_eq("b_no_req", {31'd0, any_req}, 32'd0);
        check_eq("b_pc_hold", pc, 32'h8000_0008);
`ifdef NPC_COMMIT_EN
        check_eq("b_commits", n_commit - c0, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
